// File: rtl/risc16_boot_loader.sv
// Streams a big-endian {start address, word count, data words} image into a 16-bit word memory.
// Define RISC16_LOADER_CHECKSUM_EN to expect a trailing 8-bit data checksum byte.
module risc16_boot_loader #(
  parameter int WORD_LENGTH = 16,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [7:0]             byteIn,
  input  logic                   byteValid,
  output logic                   byteReady,
  output logic [ADDR_WIDTH-1:0]  memAddress,
  output logic [WORD_LENGTH-1:0] memDataOut,
  output logic                   memWriteEn,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_ADDR_HI = 4'd1;
  localparam logic [3:0] S_ADDR_LO = 4'd2;
  localparam logic [3:0] S_CNT_HI  = 4'd3;
  localparam logic [3:0] S_CNT_LO  = 4'd4;
  localparam logic [3:0] S_DATA_HI = 4'd5;
  localparam logic [3:0] S_DATA_LO = 4'd6;
  localparam logic [3:0] S_WRITE   = 4'd7;
  localparam logic [3:0] S_CSUM    = 4'd8;
  localparam logic [3:0] S_FIN     = 4'd9;

  // State entered once the last data word (or an empty header) has been handled.
`ifdef RISC16_LOADER_CHECKSUM_EN
  localparam logic [3:0] S_TAIL = S_CSUM;
`else
  localparam logic [3:0] S_TAIL = S_FIN;
`endif

  logic [3:0]             r_state;
  logic [7:0]             r_addr_hi;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [WORD_LENGTH-1:0] r_data;
  logic [15:0]            r_count;
  logic                   w_accept;

  assign w_accept   = byteValid & byteReady;
  assign byteReady  = r_state inside {S_ADDR_HI, S_ADDR_LO, S_CNT_HI, S_CNT_LO,
                                      S_DATA_HI, S_DATA_LO, S_CSUM};
  assign busy       = !(r_state == S_IDLE || r_state == S_FIN);
  assign memWriteEn = (r_state == S_WRITE);
  assign done       = (r_state == S_FIN);
  assign memAddress = r_addr;
  assign memDataOut = r_data;

  // NOTE: async reset drops the FSM to IDLE at once; every register here uses <= so all
  // updates in one edge see the pre-edge values (r_count test in WRITE relies on this).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr_hi <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_count   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_FIN: if (start) r_state <= S_ADDR_HI;
        S_ADDR_HI: if (w_accept) begin
          r_addr_hi <= byteIn;
          r_state   <= S_ADDR_LO;
        end
        S_ADDR_LO: if (w_accept) begin
          r_addr  <= ADDR_WIDTH'({r_addr_hi, byteIn[7:1], 1'b0});
          r_state <= S_CNT_HI;
        end
        S_CNT_HI: if (w_accept) begin
          r_count[15:8] <= byteIn;
          r_state       <= S_CNT_LO;
        end
        S_CNT_LO: if (w_accept) begin
          r_count[7:0] <= byteIn;
          r_state      <= ({r_count[15:8], byteIn} != 16'd0) ? S_DATA_HI : S_TAIL;
        end
        S_DATA_HI: if (w_accept) begin
          r_data[15:8] <= byteIn;
          r_state      <= S_DATA_LO;
        end
        S_DATA_LO: if (w_accept) begin
          r_data[7:0] <= byteIn;
          r_state     <= S_WRITE;
        end
        S_WRITE: begin
          r_addr  <= r_addr + ADDR_WIDTH'(2);
          r_count <= r_count - 16'd1;
          r_state <= (r_count == 16'd1) ? S_TAIL : S_DATA_HI;
        end
`ifdef RISC16_LOADER_CHECKSUM_EN
        S_CSUM: if (w_accept) r_state <= S_FIN;
`else
        S_CSUM: r_state <= S_FIN;
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef RISC16_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;
  logic       r_error;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_csum  <= '0;
      r_error <= 1'b0;
    end else if ((r_state == S_IDLE || r_state == S_FIN) && start) begin
      r_csum  <= '0;
      r_error <= 1'b0;
    end else if (w_accept && (r_state == S_DATA_HI || r_state == S_DATA_LO)) begin
      r_csum <= r_csum + byteIn;
    end else if (w_accept && r_state == S_CSUM) begin
      r_error <= (byteIn != r_csum);
    end
  end

  assign error = r_error;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_risc16_boot_loader.sv
// Directed bench for risc16_boot_loader: table of load sessions plus reset and stall sequences.
module tb_risc16_boot_loader;

`ifdef RISC16_LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byteIn = 8'h00;
  logic        byteValid = 1'b0;
  logic        byteReady;
  logic [15:0] memAddress;
  logic [15:0] memDataOut;
  logic        memWriteEn;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  logic [31:0] wr_q[$];

  typedef struct {
    int          n;      // stream bytes, excluding checksum
    logic [63:0] bytes;  // first byte in bits [63:56]
    logic [7:0]  csum;
    int          nwr;
    logic [31:0] w0;     // {addr, data}
    logic [31:0] w1;
    logic        err;
  } sess_t;

  sess_t tbl[5];

  risc16_boot_loader #(.WORD_LENGTH(16), .ADDR_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .byteIn(byteIn), .byteValid(byteValid),
    .byteReady(byteReady), .memAddress(memAddress), .memDataOut(memDataOut),
    .memWriteEn(memWriteEn), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (memWriteEn === 1'b1) wr_q.push_back({memAddress, memDataOut});

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered and left on a negedge; optional random gaps with a stray start pulse.
  task automatic send_byte(input logic [7:0] b, input bit stall);
    int n = 0;
    if (stall) begin
      repeat ($urandom_range(0, 3)) begin
        if ($urandom_range(0, 1) == 1) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    byteIn    = b;
    byteValid = 1'b1;
    while (byteReady !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (byteReady !== 1'b1) check("ready_timeout", byteReady, 1'b1);
    @(negedge clk);
    byteValid = 1'b0;
  endtask

  task automatic run_session(input int k, input bit stall);
    logic [31:0] exp_w;
    wr_q.delete();
    do_start();
    check($sformatf("s%0d_busy_after_start", k), busy, 1'b1);
    check($sformatf("s%0d_done_cleared", k), done, 1'b0);
    for (int i = 0; i < tbl[k].n; i++) send_byte(tbl[k].bytes[63-8*i -: 8], stall);
`ifdef RISC16_LOADER_CHECKSUM_EN
    send_byte(tbl[k].csum, stall);
`endif
    repeat (4) @(negedge clk);
    check($sformatf("s%0d_write_count", k), wr_q.size(), tbl[k].nwr);
    for (int w = 0; w < tbl[k].nwr; w++) begin
      exp_w = (w == 0) ? tbl[k].w0 : tbl[k].w1;
      check($sformatf("s%0d_write%0d", k, w), (w < wr_q.size()) ? wr_q[w] : 32'hxxxxxxxx, exp_w);
    end
    check($sformatf("s%0d_done", k), done, 1'b1);
    check($sformatf("s%0d_busy", k), busy, 1'b0);
    check($sformatf("s%0d_error", k), error, tbl[k].err);
    check($sformatf("s%0d_ready_idle", k), byteReady, 1'b0);
  endtask

  initial begin
    tbl[0] = '{8, 64'h0010_0002_ABCD_1234, 8'hBE, 2, 32'h0010_ABCD, 32'h0012_1234, 1'b0};
    tbl[1] = '{8, 64'hFFFF_0002_1122_3344, 8'hAA, 2, 32'hFFFE_1122, 32'h0000_3344, 1'b0};
    tbl[2] = '{4, 64'h0100_0000_0000_0000, 8'h00, 0, 32'h0, 32'h0, 1'b0};
    tbl[3] = '{6, 64'h0020_0001_0102_0000, 8'h00, 1, 32'h0020_0102, 32'h0, CK_EN};
    tbl[4] = '{6, 64'h1235_0001_DEAD_0000, 8'h8B, 1, 32'h1234_DEAD, 32'h0, 1'b0};

    // Reset state
    @(negedge clk);
    check("rst_ready", byteReady, 1'b0);
    check("rst_we", memWriteEn, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_addr", memAddress, 16'h0000);
    check("rst_data", memDataOut, 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 1'b0);

    for (int k = 0; k < 5; k++) run_session(k, 1'b0);

    // Reset after the high data byte: outputs drop without a clock edge, no write lands
    wr_q.delete();
    do_start();
    for (int i = 0; i < 5; i++) send_byte(tbl[0].bytes[63-8*i -: 8], 1'b0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ready", byteReady, 1'b0);
    check("mid_rst_we", memWriteEn, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_error", error, 1'b0);
    check("mid_rst_addr", memAddress, 16'h0000);
    check("mid_rst_data", memDataOut, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_no_write", wr_q.size(), 0);
    check("mid_rst_idle_busy", busy, 1'b0);
    run_session(0, 1'b0);

    // Stalled streams with start pulses while busy
    run_session(0, 1'b1);
    run_session(1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
